seven_seg_scan: RTL and testbench
=================================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter GAP_CYCLES, default 4, clock cycles all anodes stay off after each digit change (legal 1..255).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 E190  input  1  scan-enable pulse from the enable divider; one clk wide, about 190 Hz.
REQ-005 value  input  16  four hex digits; value[3:0] = digit 0 (rightmost), value[15:12] = digit 3.
REQ-006 dp_in  input  4  decimal-point request per digit, 1 = lit.
REQ-007 an  output  4  anode selects, active-low; an[k]=0 drives digit k.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 dp  output  1  decimal point, active-low.

Function
REQ-010 The block SHALL keep a 2-bit scan pointer that advances by 1 on each clock edge with E190=1, wrapping 3->0.
REQ-011 The block SHALL copy value and dp_in into a snapshot register only on the edge where the pointer wraps 3->0; digits 0..3 of one frame SHALL always come from the same snapshot (no tearing).
REQ-012 FSM states: IDLE (after reset, until first E190), GAP, DRIVE; any E190 moves to GAP from any state.
REQ-013 GAP: an=4'hF, seg=7'h7F, dp=1; a counter loaded with GAP_CYCLES-1 on entry decrements each cycle; at 0 the FSM moves to DRIVE.
REQ-014 DRIVE: an has only bit [pointer] low; seg/dp show the snapshot nibble/bit for that digit; held until the next E190.
REQ-015 Timing: with E190 high before edge t, an goes 4'hF at t; the new digit is driven from edge t+GAP_CYCLES on.
REQ-016 E190 during GAP SHALL advance the pointer and reload the gap counter (gap restarts, no DRIVE cycle in between).
REQ-017 Hex decode (seg hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-018 an, seg and dp SHALL be registered outputs (no combinational path from any input).
REQ-019 value/dp_in changes outside the wrap edge SHALL have no effect on outputs until the next wrap.

Reset
REQ-020 While reset=1: an=4'hF, seg=7'h7F, dp=1, pointer=3, snapshot=0, gap counter=0, FSM=IDLE.
REQ-021 Reset asserted mid-frame or mid-gap SHALL force the REQ-020 values immediately, asynchronously.
REQ-022 The first E190 after reset SHALL wrap the pointer to 0, capture the snapshot and enter GAP.

Configuration
REQ-023 Macro LEADING_ZERO_BLANK_EN defined: a digit k>0 is blanked in DRIVE (an stays 4'hF, seg=7'h7F, dp=1) when snapshot nibbles k..3 are all zero and its snapshot dp bit is 0; digit 0 is never blanked.
REQ-024 Macro not defined: all four digits are always driven, leading zeros shown as "0"; there is no blanking logic.

Verification
REQ-025 Reset, then E190 once, value=16'h1234, GAP_CYCLES=4 -> an=F for 4 cycles after the tick edge, then an=4'b1110, seg=7'h19.
REQ-026 Four further ticks 8 clk apart -> an cycles 1101/1011/0111/1110 with seg 30/24/79/19.
REQ-027 value changed to 16'hABCD while digit 2 is driven -> digits 2,3 still show 2,1; after the wrap, digit 0 shows seg=7'h21.
REQ-028 Two E190 pulses 2 clk apart -> pointer advances twice, one contiguous gap of 2+GAP_CYCLES cycles, no glitch DRIVE.
REQ-029 Reset pulsed while an=4'b1011 -> an=4'hF, seg=7'h7F, dp=1 in the same cycle; the next tick shows digit 0 of value.
REQ-030 With LEADING_ZERO_BLANK_EN, value=16'h0005, dp_in=4'b0100 -> digit 3 dark, digit 2 shows "0" with dp=0, digit 1 dark, digit 0 shows seg=7'h12; without it, all four digits are driven.

Source files
------------

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for a four-digit common-anode display.
// Each E190 tick moves the scan to the next digit. All anodes are then held off
// for GAP_CYCLES clocks to prevent ghosting. After the gap, the selected digit is
// driven from a snapshot of value/dp_in. The snapshot is refreshed only when the
// scan wraps back to digit 0, so all four digits of a frame come from one snapshot.
// All outputs are registered and active-low.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
// A leading zero digit is not blanked when its decimal point is requested.
module seven_seg_scan #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E190,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_t      state_r, state_s;
    logic [1:0]  ptr_r, ptr_s;
    logic [15:0] snap_val_r, snap_val_s;
    logic [3:0]  snap_dp_r, snap_dp_s;
    logic [7:0]  gap_cnt_r, gap_cnt_s;
    logic [3:0]  an_r, an_s;
    logic [6:0]  seg_r, seg_s;
    logic        dp_r, dp_s;
    logic [3:0]  nibble_s;
    logic        blank_s;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // A digit above 0 is a leading zero when it and every higher nibble are zero.
    // Digit 0 is never treated as a leading zero.
    function automatic logic is_leading_zero(input logic [15:0] v, input logic [1:0] k);
        logic res;
        case (k)
            2'd1:    res = (v[15:4]  == 12'h000);
            2'd2:    res = (v[15:8]  == 8'h00);
            2'd3:    res = (v[15:12] == 4'h0);
            default: res = 1'b0;
        endcase
        return res;
    endfunction
`endif

    // Next-state logic: scan pointer, frame snapshot, gap counter and FSM.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        snap_val_s = snap_val_r;
        snap_dp_s  = snap_dp_r;
        gap_cnt_s  = gap_cnt_r;
        if (E190) begin
            ptr_s     = ptr_r + 2'd1;
            state_s   = ST_GAP;
            gap_cnt_s = GAP_LOAD;
            if (ptr_r == 2'd3) begin
                snap_val_s = value;
                snap_dp_s  = dp_in;
            end else begin
                snap_val_s = snap_val_r;
                snap_dp_s  = snap_dp_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_GAP: begin
                    if (gap_cnt_r == 8'd0) begin
                        state_s = ST_DRIVE;
                    end else begin
                        gap_cnt_s = gap_cnt_r - 8'd1;
                    end
                end
                ST_DRIVE: begin
                    state_s = ST_DRIVE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output pattern computed from the next state so registered outputs change on the tick edge.
    always_comb begin
        an_s     = 4'hF;
        seg_s    = 7'h7F;
        dp_s     = 1'b1;
        nibble_s = snap_val_s[{ptr_s, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank_s  = is_leading_zero(snap_val_s, ptr_s) && !snap_dp_s[ptr_s];
`else
        blank_s  = 1'b0;
`endif
        if ((state_s == ST_DRIVE) && !blank_s) begin
            an_s  = ~(4'b0001 << ptr_s);
            seg_s = hex7(nibble_s);
            dp_s  = ~snap_dp_s[ptr_s];
        end else begin
            an_s  = 4'hF;
            seg_s = 7'h7F;
            dp_s  = 1'b1;
        end
    end

    // State and registered-output update; reset forces everything dark at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 2'd3;
            snap_val_r <= 16'h0000;
            snap_dp_r  <= 4'h0;
            gap_cnt_r  <= 8'd0;
            an_r       <= 4'hF;
            seg_r      <= 7'h7F;
            dp_r       <= 1'b1;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            snap_val_r <= snap_val_s;
            snap_dp_r  <= snap_dp_s;
            gap_cnt_r  <= gap_cnt_s;
            an_r       <= an_s;
            seg_r      <= seg_s;
            dp_r       <= dp_s;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Testbench for seven_seg_scan.
// A frame-level model tracks the tick count, the cycles since the last tick and
// the captured frame. The model is compared with the outputs on every falling edge.
// Directed ticks with literal expectations pin the model itself.
module tb_seven_seg_scan;

    localparam int GAP = 4;

    logic        clk;
    logic        reset;
    logic        E190;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_checks;
    int n_fail;

    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seven_seg_scan #(.GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .E190  (E190),
        .value (value),
        .dp_in (dp_in),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: ticks since reset, edges since last tick, frame captured at each wrap.
    int          m_ticks;
    int          m_since;
    logic [15:0] m_val;
    logic [3:0]  m_dp;

    // Advance the frame-level model on each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            m_ticks <= 0;
            m_since <= 0;
            m_val   <= 16'h0000;
            m_dp    <= 4'h0;
        end else if (E190) begin
            if ((m_ticks % 4) == 0) begin
                m_val <= value;
                m_dp  <= dp_in;
            end
            m_ticks <= m_ticks + 1;
            m_since <= 0;
        end else begin
            m_since <= m_since + 1;
        end
    end

    // Compare the outputs with the model on every falling edge.
    always @(negedge clk) begin
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         d;
        logic       blank;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (!reset && m_ticks > 0 && m_since >= GAP) begin
            d     = (m_ticks - 1) % 4;
            blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            if (d > 0 && (m_val >> (4 * d)) == 16'h0000 && !m_dp[d]) blank = 1'b1;
`endif
            if (!blank) begin
                e_an  = 4'hF;
                e_an[d] = 1'b0;
                e_seg = SEG_TAB[(m_val >> (4 * d)) & 16'h000F];
                e_dp  = ~m_dp[d];
            end
        end
        n_checks++;
        if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
            n_fail++;
            $display("FAIL model t=%0t an/seg/dp got %b/%h/%b expected %b/%h/%b",
                     $time, an, seg, dp, e_an, e_seg, e_dp);
        end
    end

    task automatic chk(input string name, input logic [3:0] a_e, input logic [6:0] s_e, input logic d_e);
        n_checks++;
        if (an !== a_e || seg !== s_e || dp !== d_e) begin
            n_fail++;
            $display("FAIL %s an/seg/dp got %b/%h/%b expected %b/%h/%b",
                     name, an, seg, dp, a_e, s_e, d_e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        E190 = 1'b1;
        @(negedge clk);
        E190 = 1'b0;
    endtask

    // Tick, confirm the gap is dark, then confirm the newly driven digit.
    task automatic tick_chk(input string name, input logic [3:0] a_e, input logic [6:0] s_e, input logic d_e);
        tick();
        chk({name, "_gap0"}, 4'hF, 7'h7F, 1'b1);
        repeat (GAP - 1) @(negedge clk);
        chk({name, "_gapend"}, 4'hF, 7'h7F, 1'b1);
        @(negedge clk);
        chk(name, a_e, s_e, d_e);
        repeat (3) @(negedge clk);
    endtask

    // Directed stimulus sequence.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        E190     = 1'b0;
        value    = 16'h1234;
        dp_in    = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset", 4'hF, 7'h7F, 1'b1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle", 4'hF, 7'h7F, 1'b1);

        // First frame and a full scan around the display.
        tick_chk("d0_1234", 4'b1110, 7'h19, 1'b1);
        tick_chk("d1_1234", 4'b1101, 7'h30, 1'b1);
        tick_chk("d2_1234", 4'b1011, 7'h24, 1'b1);
        tick_chk("d3_1234", 4'b0111, 7'h79, 1'b1);
        tick_chk("d0_again", 4'b1110, 7'h19, 1'b1);

        // A value change mid-frame must not tear the frame.
        tick_chk("d1_pre", 4'b1101, 7'h30, 1'b1);
        tick_chk("d2_pre", 4'b1011, 7'h24, 1'b1);
        value = 16'hABCD;
        repeat (2) @(negedge clk);
        chk("d2_hold", 4'b1011, 7'h24, 1'b1);
        tick_chk("d3_hold", 4'b0111, 7'h79, 1'b1);
        tick_chk("d0_abcd", 4'b1110, 7'h21, 1'b1);

        // Two ticks two cycles apart make one contiguous gap.
        @(negedge clk); E190 = 1'b1;
        @(negedge clk); E190 = 1'b0;
        @(negedge clk); E190 = 1'b1;
        @(negedge clk); E190 = 1'b0;
        chk("dbl_gap0", 4'hF, 7'h7F, 1'b1);
        repeat (GAP - 1) @(negedge clk);
        chk("dbl_gapend", 4'hF, 7'h7F, 1'b1);
        @(negedge clk);
        chk("dbl_d2", 4'b1011, 7'h03, 1'b1);

        // Asynchronous reset asserted mid-cycle while digit 2 is lit.
        #2 reset = 1'b1;
        #1 chk("async_rst", 4'hF, 7'h7F, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        tick_chk("post_rst_d0", 4'b1110, 7'h21, 1'b1);

        // Leading zeros with a decimal point on digit 2.
        value = 16'h0005;
        dp_in = 4'b0100;
        tick_chk("abcd_d1", 4'b1101, 7'h46, 1'b1);
        tick_chk("abcd_d2", 4'b1011, 7'h03, 1'b1);
        tick_chk("abcd_d3", 4'b0111, 7'h08, 1'b1);
        tick_chk("z_d0", 4'b1110, 7'h12, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
        tick_chk("z_d1", 4'hF, 7'h7F, 1'b1);
        tick_chk("z_d2", 4'b1011, 7'h40, 1'b0);
        tick_chk("z_d3", 4'hF, 7'h7F, 1'b1);
`else
        tick_chk("z_d1", 4'b1101, 7'h40, 1'b1);
        tick_chk("z_d2", 4'b1011, 7'h40, 1'b0);
        tick_chk("z_d3", 4'b0111, 7'h40, 1'b1);
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
